// File: rtl/rbm_frame_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rbm_frame_driver_pkg
// Purpose  : Shared types and helpers for the RBM frame driver: sequencer
//            state encoding and a compile-time ceiling-divide helper.
// Ports    : none (package)
// Config   : FRAME_TIMEOUT_EN is consumed by rbm_frame_driver, not here.
// Revision : 1.0 - initial release
// ============================================================================
package rbm_frame_driver_pkg;

    // Sequencer states. The values are fixed so that the encoding matches the
    // state numbering used by the rest of the RBM code base.
    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_KICK    = 3'd1,
        ST_RUN     = 3'd2,
        ST_SCAN    = 3'd3,
        ST_PRESENT = 3'd4
    } state_t;

    // Number of stream words needed to cover a vector of num bits.
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rbm_frame_driver_argmax_scan.sv
`default_nettype none
// ============================================================================
// Module   : argmax_scan
// Purpose  : Sequential arg-max over NUM_CLASSES vote counters, one class per
//            cycle starting at index 0. The best entry is only replaced on a
//            strictly greater vote, so ties resolve to the lowest index.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            i_start         - pulse: restart the scan on the next cycle
//            i_votes         - packed vote counters, class k at bits k*VW
//            o_done          - high during the cycle that compares the last class
//            o_best_idx      - winning class index (valid after o_done)
//            o_best_votes    - winning vote count (valid after o_done)
// Revision : 1.0 - initial release
// ============================================================================
module argmax_scan
    import rbm_frame_driver_pkg::*;
#(
    parameter int NUM_CLASSES = 10,
    parameter int VOTE_WIDTH  = 12,
    parameter int IDX_WIDTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_start,
    input  logic [NUM_CLASSES*VOTE_WIDTH-1:0] i_votes,
    output logic                              o_done,
    output logic [IDX_WIDTH-1:0]              o_best_idx,
    output logic [VOTE_WIDTH-1:0]             o_best_votes
);

    logic [VOTE_WIDTH-1:0] w_votes [NUM_CLASSES];
    logic                  r_active;
    logic [IDX_WIDTH-1:0]  r_idx;
    logic [IDX_WIDTH-1:0]  r_best_idx;
    logic [VOTE_WIDTH-1:0] r_best_votes;
    logic                  w_last;

    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_unpack
        assign w_votes[k] = i_votes[k*VOTE_WIDTH +: VOTE_WIDTH];
    end

    assign w_last = r_active && (r_idx == IDX_WIDTH'(NUM_CLASSES - 1));

    // Best value starts at zero: a class with zero votes never displaces
    // index 0, which gives the same answer as seeding with class 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active     <= 1'b0;
            r_idx        <= '0;
            r_best_idx   <= '0;
            r_best_votes <= '0;
        end else if (i_start) begin
            r_active     <= 1'b1;
            r_idx        <= '0;
            r_best_idx   <= '0;
            r_best_votes <= '0;
        end else if (r_active) begin
            if (w_votes[r_idx] > r_best_votes) begin
                r_best_votes <= w_votes[r_idx];
                r_best_idx   <= r_idx;
            end
            if (w_last) begin
                r_active <= 1'b0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign o_done       = w_last;
    assign o_best_idx   = r_best_idx;
    assign o_best_votes = r_best_votes;

endmodule
`default_nettype wire

// File: rtl/rbm_frame_driver.sv
`default_nettype none
// ============================================================================
// Module   : rbm_frame_driver
// Purpose  : Packs a stream of input words into the RBM input vector, kicks
//            the inference core, snapshots its vote counters on finish and
//            returns the arg-max class over a valid/ready result port.
// Ports    : clock, reset            - clock, asynchronous active-low reset
//            s_valid/s_ready/s_data/s_last - input word stream
//            rbm_reset, data_valid, InputData - drive the inference core
//            OutputData, finish      - vote counters / done from the core
//            label_valid/label_ready/label/label_votes - result handshake
//            frame_err               - sticky framing / watchdog error
//            busy                    - high in every state except LOAD
// Config   : `define FRAME_TIMEOUT_EN adds a RUN-state watchdog of
//            TIMEOUT_CYCLES cycles; on expiry the label is all ones with
//            zero votes and frame_err is set.
// Revision : 1.0 - initial release
// ============================================================================
module rbm_frame_driver
    import rbm_frame_driver_pkg::*;
#(
    parameter int GENERAL_INPUT_DIM = 784,
    parameter int OUTPUT_DIM        = 10,
    parameter int W_BITLENGTH       = 12,
    parameter int WORD_WIDTH        = 16,
    parameter int LABEL_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES    = 200000
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [WORD_WIDTH-1:0]             s_data,
    input  logic                              s_last,
    output logic                              rbm_reset,
    output logic                              data_valid,
    output logic [GENERAL_INPUT_DIM-1:0]      InputData,
    input  logic [OUTPUT_DIM*W_BITLENGTH-1:0] OutputData,
    input  logic                              finish,
    output logic                              label_valid,
    input  logic                              label_ready,
    output logic [LABEL_WIDTH-1:0]            label,
    output logic [W_BITLENGTH-1:0]            label_votes,
    output logic                              frame_err,
    output logic                              busy
);

    localparam int c_num_words  = ceil_div(GENERAL_INPUT_DIM, WORD_WIDTH);
    localparam int c_frame_bits = c_num_words * WORD_WIDTH;
    localparam int c_cnt_w      = $clog2(c_num_words + 1);

    state_t                          r_state;
    state_t                          w_state_d;
    logic                            r_s_ready;
    logic                            r_rbm_reset;
    logic [c_frame_bits-1:0]         r_frame;
    logic [c_cnt_w-1:0]              r_word_cnt;
    logic [OUTPUT_DIM*W_BITLENGTH-1:0] r_votes_snap;
    logic                            r_frame_err;

    logic                            w_accept;
    logic                            w_last_word;
    logic                            w_scan_start;
    logic                            w_scan_done;
    logic                            w_err_set;
    logic                            w_label_hs;
    logic [LABEL_WIDTH-1:0]          w_best_idx;
    logic [W_BITLENGTH-1:0]          w_best_votes;
`ifdef FRAME_TIMEOUT_EN
    localparam int c_to_w = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_to_w-1:0]               r_run_cnt;
    logic                            r_timed_out;
    logic                            w_timeout;
`endif

    // s_ready is registered from the next state, so it is low while reset is
    // held and only one word is ever accepted per LOAD cycle.
    assign w_accept    = s_valid && r_s_ready;
    assign w_last_word = (r_word_cnt == c_cnt_w'(c_num_words - 1));
    assign w_label_hs  = (r_state == ST_PRESENT) && label_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d    = r_state;
        w_scan_start = 1'b0;
        w_err_set    = 1'b0;
`ifdef FRAME_TIMEOUT_EN
        w_timeout    = 1'b0;
`endif
        case (r_state)
            ST_LOAD: begin
                if (w_accept) begin
                    if (w_last_word || s_last) begin
                        w_state_d = ST_KICK;
                    end
                    // Early s_last and missing s_last are both framing errors.
                    if (w_last_word != s_last) begin
                        w_err_set = 1'b1;
                    end
                end
            end
            ST_KICK: begin
                w_state_d = ST_RUN;
            end
            ST_RUN: begin
                if (finish) begin
                    w_state_d    = ST_SCAN;
                    w_scan_start = 1'b1;
                end
`ifdef FRAME_TIMEOUT_EN
                else if (r_run_cnt == c_to_w'(TIMEOUT_CYCLES - 1)) begin
                    w_state_d = ST_PRESENT;
                    w_timeout = 1'b1;
                    w_err_set = 1'b1;
                end
`endif
            end
            ST_SCAN: begin
                if (w_scan_done) begin
                    w_state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (label_ready) begin
                    w_state_d = ST_LOAD;
                end
            end
            default: begin
                w_state_d = ST_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_d;
        end
    end

    // ------------------------------------------------------------------
    // Load path, handshake registers, snapshot and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s_ready    <= 1'b0;
            r_rbm_reset  <= 1'b1;
            r_frame      <= '0;
            r_word_cnt   <= '0;
            r_votes_snap <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_s_ready   <= (w_state_d == ST_LOAD);
            r_rbm_reset <= (w_state_d == ST_KICK);

            if (w_accept) begin
                // Clearing on the first word leaves the tail of a short
                // frame zero-filled without a separate fill pass.
                if (r_word_cnt == '0) begin
                    r_frame <= '0;
                end
                r_frame[r_word_cnt*WORD_WIDTH +: WORD_WIDTH] <= s_data;
                r_word_cnt <= r_word_cnt + 1'b1;
            end else if (w_label_hs) begin
                r_word_cnt <= '0;
            end

            if (w_scan_start) begin
                r_votes_snap <= OutputData;
            end

            if (w_err_set) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Arg-max scanner
    // ------------------------------------------------------------------
    argmax_scan #(
        .NUM_CLASSES (OUTPUT_DIM),
        .VOTE_WIDTH  (W_BITLENGTH),
        .IDX_WIDTH   (LABEL_WIDTH)
    ) u_argmax_scan (
        .clk          (clock),
        .rst_n        (reset),
        .i_start      (w_scan_start),
        .i_votes      (r_votes_snap),
        .o_done       (w_scan_done),
        .o_best_idx   (w_best_idx),
        .o_best_votes (w_best_votes)
    );

`ifdef FRAME_TIMEOUT_EN
    // ------------------------------------------------------------------
    // RUN watchdog: counts cycles spent in RUN; the timed-out flag
    // overrides the scanner result until the label is consumed.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_run_cnt   <= '0;
            r_timed_out <= 1'b0;
        end else begin
            if (r_state == ST_RUN) begin
                r_run_cnt <= r_run_cnt + 1'b1;
            end else begin
                r_run_cnt <= '0;
            end
            if (w_timeout) begin
                r_timed_out <= 1'b1;
            end else if (w_label_hs) begin
                r_timed_out <= 1'b0;
            end
        end
    end

    assign label       = r_timed_out ? '1 : w_best_idx;
    assign label_votes = r_timed_out ? '0 : w_best_votes;
`else
    assign label       = w_best_idx;
    assign label_votes = w_best_votes;
`endif

    assign s_ready     = r_s_ready;
    assign rbm_reset   = r_rbm_reset;
    assign data_valid  = (r_state == ST_RUN);
    assign InputData   = r_frame[GENERAL_INPUT_DIM-1:0];
    assign label_valid = (r_state == ST_PRESENT);
    assign frame_err   = r_frame_err;
    assign busy        = (r_state != ST_LOAD);

endmodule
`default_nettype wire
